// File: rtl/vec_execute_stage.sv
// Vector execute stage: eight 32-bit lanes.
// Single-cycle lane-wise ALU ops go straight into the execute/memory register.
// A lane multiply takes four cycles and uses two multipliers, one lane pair per
// cycle. While it runs, StallV holds the front end.
module vec_execute_stage #(
   parameter int LANES               = 8,
   parameter int MUL_LANES_PER_CYCLE = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         PCSrcEV,
   input  logic         RegWriteEV,
   input  logic         MemtoRegEV,
   input  logic         MemWriteEV,
   input  logic [2:0]   ALUControlEV,
   input  logic [255:0] SrcAEV,
   input  logic [255:0] SrcBEV,
   input  logic [31:0]  ScalarEV,
   input  logic [255:0] WriteDataEV,
   input  logic [2:0]   WA3EV,
   input  logic         FlushEV,
   output logic         StallV,
   output logic         PCSrcMV,
   output logic         RegWriteMV,
   output logic         MemtoRegMV,
   output logic         MemWriteMV,
   output logic [255:0] ALUResultMV,
   output logic [255:0] WriteDataMV,
   output logic [2:0]   WA3MV
);

   localparam int MUL_CYCLES = LANES / MUL_LANES_PER_CYCLE;
   localparam int ACC_W      = 32 * (LANES - MUL_LANES_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(MUL_CYCLES - 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_ADDS = 3'b111;

   // state  | meaning
   // IDLE   | accepting ops; a MUL here multiplies lanes 0-1 and moves to MUL
   // MUL    | cnt 1,2: accumulate lane pair cnt; cnt 3: finish lanes 6-7, emit result
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;

   logic [3:0]   m_ctl_q, m_ctl_d;
   logic [255:0] m_res_q, m_res_d;
   logic [255:0] m_wd_q, m_wd_d;
   logic [2:0]   m_wa3_q, m_wa3_d;

   logic [255:0] alu_res;
   logic [7:0]   pair_lo_idx, pair_hi_idx;
   logic [31:0]  mul_p0, mul_p1;

   // Lane-wise single-cycle ALU. MUL goes through the shared pair multiplier instead.
   always_comb begin
      alu_res = '0;
      for (int i = 0; i < LANES; i++) begin
         unique case (ALUControlEV)
            OP_ADD:  alu_res[32*i +: 32] = SrcAEV[32*i +: 32] + SrcBEV[32*i +: 32];
            OP_SUB:  alu_res[32*i +: 32] = SrcAEV[32*i +: 32] - SrcBEV[32*i +: 32];
            OP_AND:  alu_res[32*i +: 32] = SrcAEV[32*i +: 32] & SrcBEV[32*i +: 32];
            OP_OR:   alu_res[32*i +: 32] = SrcAEV[32*i +: 32] | SrcBEV[32*i +: 32];
            OP_XOR:  alu_res[32*i +: 32] = SrcAEV[32*i +: 32] ^ SrcBEV[32*i +: 32];
            OP_SHL:  alu_res[32*i +: 32] = SrcAEV[32*i +: 32] << ScalarEV[4:0];
            OP_ADDS: alu_res[32*i +: 32] = SrcAEV[32*i +: 32] + ScalarEV;
            default: alu_res[32*i +: 32] = '0;
         endcase
      end
   end

   // Two lane multipliers. cnt is 0 in IDLE, so cnt alone selects the lane pair.
   always_comb begin
      pair_lo_idx = {cnt_q, 6'd0};
      pair_hi_idx = {cnt_q, 6'd32};
      mul_p0      = SrcAEV[pair_lo_idx +: 32] * SrcBEV[pair_lo_idx +: 32];
      mul_p1      = SrcAEV[pair_hi_idx +: 32] * SrcBEV[pair_hi_idx +: 32];
   end

   // Stall while the multiply still has lane pairs left after this cycle.
   always_comb begin
      StallV = 1'b0;
      if (!reset && !FlushEV) begin
         if (state_q == S_IDLE)
            StallV = (ALUControlEV == OP_MUL);
         else
            StallV = (cnt_q != CNT_LAST);
      end
   end

   // Next state for the multiply sequencer and the M register. The M register defaults to a bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_ctl_d = '0;
      m_res_d = '0;
      m_wd_d  = '0;
      m_wa3_d = '0;
      if (FlushEV) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (state_q == S_IDLE) begin
         if (ALUControlEV == OP_MUL) begin
            acc_d[63:0] = {mul_p1, mul_p0};
            state_d     = S_MUL;
            cnt_d       = 2'd1;
         end else begin
            m_ctl_d = {PCSrcEV, RegWriteEV, MemtoRegEV, MemWriteEV};
            m_res_d = alu_res;
            m_wd_d  = WriteDataEV;
            m_wa3_d = WA3EV;
         end
      end else begin
         if (cnt_q == CNT_LAST) begin
            m_ctl_d = {PCSrcEV, RegWriteEV, MemtoRegEV, MemWriteEV};
            m_res_d = {mul_p1, mul_p0, acc_q};
            m_wd_d  = WriteDataEV;
            m_wa3_d = WA3EV;
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            case (cnt_q)
               2'd1:    acc_d[127:64]  = {mul_p1, mul_p0};
               2'd2:    acc_d[191:128] = {mul_p1, mul_p0};
               default: acc_d          = acc_q;
            endcase
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   // Register update. Reset clears the sequencer and the M outputs but leaves the accumulator alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         m_ctl_q <= '0;
         m_res_q <= '0;
         m_wd_q  <= '0;
         m_wa3_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_ctl_q <= m_ctl_d;
         m_res_q <= m_res_d;
         m_wd_q  <= m_wd_d;
         m_wa3_q <= m_wa3_d;
      end
   end

   // The accumulator is only meaningful mid-multiply, so it has no reset.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   assign PCSrcMV     = m_ctl_q[3];
   assign RegWriteMV  = m_ctl_q[2];
   assign MemtoRegMV  = m_ctl_q[1];
   assign MemWriteMV  = m_ctl_q[0];
   assign ALUResultMV = m_res_q;
   assign WriteDataMV = m_wd_q;
   assign WA3MV       = m_wa3_q;

endmodule

// File: tb/tb_vec_execute_stage.sv
// Testbench for vec_execute_stage: directed scenarios plus randomized traffic,
// compared against a lane-level behavioural model.
module tb_vec_execute_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         PCSrcEV, RegWriteEV, MemtoRegEV, MemWriteEV;
   logic [2:0]   ALUControlEV;
   logic [255:0] SrcAEV, SrcBEV, WriteDataEV;
   logic [31:0]  ScalarEV;
   logic [2:0]   WA3EV;
   logic         FlushEV;
   logic         StallV;
   logic         PCSrcMV, RegWriteMV, MemtoRegMV, MemWriteMV;
   logic [255:0] ALUResultMV, WriteDataMV;
   logic [2:0]   WA3MV;

   int checks = 0;
   int errors = 0;

   // Model state: the number of multiply cycles already spent (0 = none in flight).
   int           mul_spent = 0;
   logic         e_stall = 1'b0;
   logic [3:0]   e_ctl;
   logic [255:0] e_res, e_wd;
   logic [2:0]   e_wa3;
   logic         seen_stall;

   vec_execute_stage #(.LANES(8), .MUL_LANES_PER_CYCLE(2)) dut (
      .clk(clk), .reset(reset),
      .PCSrcEV(PCSrcEV), .RegWriteEV(RegWriteEV), .MemtoRegEV(MemtoRegEV), .MemWriteEV(MemWriteEV),
      .ALUControlEV(ALUControlEV), .SrcAEV(SrcAEV), .SrcBEV(SrcBEV), .ScalarEV(ScalarEV),
      .WriteDataEV(WriteDataEV), .WA3EV(WA3EV), .FlushEV(FlushEV), .StallV(StallV),
      .PCSrcMV(PCSrcMV), .RegWriteMV(RegWriteMV), .MemtoRegMV(MemtoRegMV), .MemWriteMV(MemWriteMV),
      .ALUResultMV(ALUResultMV), .WriteDataMV(WriteDataMV), .WA3MV(WA3MV)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] ref_alu(input logic [2:0] op, input logic [255:0] a,
                                            input logic [255:0] b, input logic [31:0] s);
      logic [255:0] r;
      logic [31:0]  x, y, z;
      r = '0;
      for (int l = 0; l < 8; l++) begin
         x = a[32*l +: 32];
         y = b[32*l +: 32];
         case (op)
            3'd0: z = x + y;
            3'd1: z = x - y;
            3'd2: z = x & y;
            3'd3: z = x | y;
            3'd4: z = x ^ y;
            3'd5: z = x << s[4:0];
            3'd6: z = x * y;
            default: z = x + s;
         endcase
         r[32*l +: 32] = z;
      end
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int l = 0; l < 8; l++) r[32*l +: 32] = $urandom();
      return r;
   endfunction

   // One clock: predict and check StallV mid-cycle, then check the M register after the edge.
   task automatic cycle();
      logic [3:0]   n_ctl;
      logic [255:0] n_res, n_wd;
      logic [2:0]   n_wa3;
      @(negedge clk);
      n_ctl = '0; n_res = '0; n_wd = '0; n_wa3 = '0;
      if (reset || FlushEV) begin
         e_stall   = 1'b0;
         mul_spent = 0;
      end else if (mul_spent == 0 && ALUControlEV == 3'd6) begin
         e_stall   = 1'b1;
         mul_spent = 1;
      end else if (mul_spent > 0 && mul_spent < 3) begin
         e_stall   = 1'b1;
         mul_spent++;
      end else begin
         e_stall   = 1'b0;
         n_ctl     = {PCSrcEV, RegWriteEV, MemtoRegEV, MemWriteEV};
         n_res     = ref_alu(mul_spent == 3 ? 3'd6 : ALUControlEV, SrcAEV, SrcBEV, ScalarEV);
         n_wd      = WriteDataEV;
         n_wa3     = WA3EV;
         mul_spent = 0;
      end
      seen_stall = StallV;
      chk("stall", StallV, e_stall);
      @(posedge clk);
      #1;
      e_ctl = n_ctl; e_res = n_res; e_wd = n_wd; e_wa3 = n_wa3;
      chk("ctrl", {PCSrcMV, RegWriteMV, MemtoRegMV, MemWriteMV}, e_ctl);
      chk("alu_result", ALUResultMV, e_res);
      chk("write_data", WriteDataMV, e_wd);
      chk("wa3", WA3MV, e_wa3);
   endtask

   task automatic set_ctl(input logic pc, input logic rw, input logic m2r, input logic mw, input logic [2:0] wa3);
      PCSrcEV = pc; RegWriteEV = rw; MemtoRegEV = m2r; MemWriteEV = mw; WA3EV = wa3;
   endtask

   task automatic set_op(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b, input logic [31:0] s);
      ALUControlEV = op; SrcAEV = a; SrcBEV = b; ScalarEV = s;
   endtask

   logic [255:0] va, vb, vexp, pat;

   initial begin
      reset = 1'b1; FlushEV = 1'b0;
      set_ctl(0, 0, 0, 0, 0);
      set_op(3'd0, '0, '0, 0);
      WriteDataEV = '0;
      cycle();
      cycle();
      reset = 1'b0;

      // ADD with lane wrap
      va = '0; vb = '0;
      va[31:0] = 32'hFFFF_FFFF; vb[31:0] = 32'h2;
      va[255:224] = 32'd5; vb[255:224] = 32'd7;
      set_ctl(0, 1, 0, 0, 3'd3);
      set_op(3'd0, va, vb, 0);
      cycle();
      chk("add_lane0", ALUResultMV[31:0], 32'h0000_0001);
      chk("add_lane7", ALUResultMV[255:224], 32'h0000_000C);
      chk("add_regwrite", RegWriteMV, 1'b1);
      chk("add_wa3", WA3MV, 3'd3);

      // SHL by 33 uses only the low five bits of the scalar
      for (int l = 0; l < 8; l++) va[32*l +: 32] = 32'h1;
      set_ctl(0, 1, 0, 0, 3'd1);
      set_op(3'd5, va, '0, 32'd33);
      cycle();
      for (int l = 0; l < 8; l++) vexp[32*l +: 32] = 32'h2;
      chk("shl33", ALUResultMV, vexp);

      // ADDS broadcast
      for (int l = 0; l < 8; l++) begin
         va[32*l +: 32] = 32'(l);
         vexp[32*l +: 32] = 32'(l + 16);
      end
      set_op(3'd7, va, '0, 32'h10);
      cycle();
      chk("adds", ALUResultMV, vexp);

      // MUL: stall 1,1,1,0, then bubbles, then result
      for (int l = 0; l < 8; l++) begin
         va[32*l +: 32] = 32'(l + 1);
         vb[32*l +: 32] = 32'h10000;
         vexp[32*l +: 32] = 32'(l + 1) << 16;
      end
      set_ctl(0, 1, 0, 0, 3'd5);
      set_op(3'd6, va, vb, 0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("mul_stall_seq", seen_stall, k < 3);
         if (k < 3) chk("mul_bubble", {RegWriteMV, ALUResultMV[31:0]}, 33'd0);
      end
      chk("mul_result", ALUResultMV, vexp);
      chk("mul_wa3", WA3MV, 3'd5);

      // MUL where every lane product is exactly 2^32, which wraps to zero
      for (int l = 0; l < 8; l++) va[32*l +: 32] = 32'h10000;
      set_op(3'd6, va, va, 0);
      for (int k = 0; k < 4; k++) cycle();
      chk("mul_wrap", ALUResultMV, 256'd0);
      chk("mul_wrap_rw", RegWriteMV, 1'b1);

      // Flush in the third cycle of a multiply
      set_op(3'd6, va, va, 0);
      cycle();
      cycle();
      FlushEV = 1'b1;
      cycle();
      chk("flush_stall", seen_stall, 1'b0);
      chk("flush_bubble", RegWriteMV, 1'b0);
      FlushEV = 1'b0;
      va = '0; vb = '0; va[31:0] = 32'd100; vb[31:0] = 32'd23;
      set_op(3'd0, va, vb, 0);
      cycle();
      chk("after_flush_add", ALUResultMV[31:0], 32'd123);

      // Reset held two cycles in the middle of a multiply
      set_op(3'd6, va, vb, 0);
      cycle();
      reset = 1'b1;
      cycle();
      cycle();
      chk("reset_outs", {RegWriteMV, ALUResultMV}, 257'd0);
      chk("reset_stall", seen_stall, 1'b0);
      reset = 1'b0;
      set_op(3'd1, va, vb, 0);
      cycle();
      chk("after_reset_sub", ALUResultMV[31:0], 32'd77);

      // Store address plus data pass-through
      pat = rnd256();
      va = '0; vb = '0; va[31:0] = 32'h40; vb[31:0] = 32'h8;
      set_ctl(0, 0, 0, 1, 3'd0);
      WriteDataEV = pat;
      set_op(3'd0, va, vb, 0);
      cycle();
      chk("store_addr", ALUResultMV[15:0], 16'h0048);
      chk("store_data", WriteDataMV, pat);
      chk("store_mw", MemWriteMV, 1'b1);
      set_ctl(0, 1, 0, 0, 3'd2);
      cycle();
      chk("store_mw_once", MemWriteMV, 1'b0);

      // Randomized traffic; inputs are held whenever the model expects a stall
      for (int c = 0; c < 800; c++) begin
         if (e_stall) begin
            FlushEV = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 39) == 0);
         end else begin
            set_ctl($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), 3'($urandom_range(0, 7)));
            set_op(($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7)),
                   rnd256(), rnd256(), $urandom());
            WriteDataEV = rnd256();
            FlushEV = ($urandom_range(0, 11) == 0);
            reset   = ($urandom_range(0, 49) == 0);
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vec_execute_stage.md
# vec_execute_stage

Vector execute stage of the 8-lane × 32-bit SIMD pipeline. It sits directly upstream of the memory stage:
- It takes decoded 256-bit operands and control from the decode/execute register.
- It performs lane-wise ALU operations, including an iterative 4-cycle lane multiply that stalls the front end.
- It owns the execute/memory pipeline register that drives the memory stage's vector inputs (PCSrcMV … WA3MV).

## Interface
Parameters:
- LANES, 8, number of 32-bit lanes (fixed at 8; vector width 256)
- MUL_LANES_PER_CYCLE, 2, lanes multiplied per cycle (fixed at 2; multiply takes 4 cycles)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- PCSrcEV, RegWriteEV, MemtoRegEV, MemWriteEV  in  1 each  execute-stage control bits
- ALUControlEV  in  3  operation select (see Operation)
- SrcAEV  in  256  operand A, 8 lanes
- SrcBEV  in  256  operand B, 8 lanes
- ScalarEV  in  32  scalar operand for shift/broadcast ops
- WriteDataEV  in  256  store data, passed through unchanged
- WA3EV  in  3  destination vector register
- FlushEV  in  1  squash the current execute op
- StallV  out  1  combinational; upstream must hold all E inputs stable while 1
- PCSrcMV, RegWriteMV, MemtoRegMV, MemWriteMV  out  1 each  registered control to the memory stage
- ALUResultMV  out  256  registered result; bits [15:0] are the vector memory address
- WriteDataMV  out  256  registered store data
- WA3MV  out  3  registered destination

## Operation
- Lane i occupies bits [32i+31:32i], i = 0..7. All arithmetic is modulo 2^32 per lane; there is no carry between lanes and no flags.
- ALUControlEV encodings:
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: A << ScalarEV[4:0]
  - 110 MUL: low 32 bits of A×B (identical for signed and unsigned)
  - 111 ADDS: A + ScalarEV, broadcast to all lanes
- Single-cycle ops (all except 110): the result and all E inputs load into the M register at the next edge. StallV=0.
- Multiply FSM. State is IDLE or MUL, with a 2-bit counter cnt and a 192-bit accumulator for lanes 0–5.
  - IDLE with op 110 and FlushEV=0:
    - StallV=1.
    - Lanes 0–1 products go to the accumulator.
    - cnt←1, state←MUL.
    - The M register loads a bubble.
  - MUL with cnt=1 or 2:
    - StallV=1.
    - Lanes 2cnt and 2cnt+1 go to the accumulator.
    - cnt←cnt+1.
    - The M register loads a bubble.
  - MUL with cnt=3:
    - StallV=0.
    - Lanes 6–7 are computed combinationally.
    - The M register loads {lanes 6–7, accumulator lanes 0–5} with the E control, WriteDataEV and WA3EV.
    - state←IDLE, cnt←0.
- Bubble definition: all four control bits 0; ALUResultMV, WriteDataMV and WA3MV are 0.
- A multiply is started only from IDLE. Back-to-back multiplies each take a full 4 cycles.
- FlushEV=1 in any state, including mid-multiply:
  - The M register loads a bubble.
  - state←IDLE, cnt←0, accumulator contents are don't-care.
  - StallV=0 in that cycle.
  - FlushEV has priority over starting or continuing a multiply.
- Reset (including mid-multiply):
  - All M outputs are 0, StallV=0, state=IDLE, cnt=0.
  - Reset has priority over flush.

## Timing
- Single-cycle op presented in cycle N: M outputs are valid in cycle N+1. Throughput is 1 op/cycle.
- MUL presented in cycle N:
  - StallV=1 in cycles N, N+1, N+2 and 0 in cycle N+3.
  - A bubble appears on the M outputs in cycles N+1..N+3.
  - The result appears in cycle N+4.
  - The upstream stage advances at the N+3 edge.
- StallV is a combinational function of state, cnt, ALUControlEV, FlushEV and reset. It has no dependency on the M outputs.
- E inputs are sampled live every cycle. Changing them while StallV=1 is a protocol violation and the result is undefined.

## Test plan
- Reset: hold reset 2 cycles mid-traffic → all M outputs 0, StallV=0. The first op after release completes normally.
- ADD wrap: lane 0 A=0xFFFFFFFF, B=0x2; lane 7 A=5, B=7; RegWriteEV=1, WA3EV=3 → next cycle lane 0=0x00000001, lane 7=0x0000000C, RegWriteMV=1, WA3MV=3.
- SHL/ADDS: SHL with ScalarEV=33 and A=0x1 in all lanes → all lanes 0x2. ADDS with ScalarEV=0x10 and A lanes 0..7=i → lanes 0x10..0x17.
- MUL: A lane i=i+1, B lane i=0x10000 → StallV pattern 1,1,1,0. M outputs are bubbles for 3 cycles, then lane i=(i+1)<<16 in cycle N+4. Then a MUL with A=0x10000, B=0x10000 → lane=0.
- Flush mid-multiply: FlushEV=1 in cycle N+2 of a MUL → StallV=0 that cycle, bubble on M, state IDLE. A following ADD completes in 1 cycle with a correct result.
- Store pass-through: MemWriteEV=1, ADD of base 0x0040 + offset 0x0008, WriteDataEV=pattern → ALUResultMV[15:0]=0x0048, WriteDataMV=pattern, MemWriteMV=1 for exactly one cycle.
